keycode_rx_fifo: RTL and testbench
==================================

Name: keycode_rx_fifo

Overview:
- Hardware-to-CPU counterpart of the keycode output PIO: captures keycodes produced by fabric logic (keyboard decoder) and buffers them in a small FIFO.
- The soft CPU drains the FIFO through a 4-word Avalon-MM slave (zero wait states, same bus style as the chesssoc PIOs).
- Sits between the keyboard front end and the chesssoc interconnect; replaces CPU polling of a raw keycode wire.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- KW, 8, keycode width in bits; <= 8.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- address  in  2  Avalon word address
- chipselect  in  1  Avalon select
- read_n  in  1  Avalon read strobe, active-low
- write_n  in  1  Avalon write strobe, active-low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data; combinational from address and registered state
- in_keycode  in  KW  keycode from fabric
- in_valid  in  1  push request, one keycode per cycle
- in_ready  out  1  = ~full (registered state)
- irq  out  1  only with KEYCODE_IRQ_EN; see Optional Feature

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset state: FIFO empty, count=0, overflow=0, irq_en=0. Therefore in_ready=1, irq=0, and readdata=0 for any unselected or empty read.
- A bus access is valid when chipselect=1. Read is read_n=0; write is write_n=0. Each access lasts one cycle with no wait states.
- Register map:
  - addr 0 DATA (RO): [KW-1:0] head keycode, [8] valid (=~empty), other bits 0. A read with valid=1 pops the head at that clock edge. A read when empty returns 0 and pops nothing.
  - addr 1 STATUS: [$clog2(DEPTH):0] count, [8] empty, [9] full, [10] overflow (sticky). Writing 1 to bit 10 clears overflow; writes to other bits are ignored.
  - addr 2 CONTROL: [0] irq_en (R/W), [1] flush (W, self-clearing, reads 0).
  - addr 3: reads 0; writes are ignored.
- Push: in_valid=1 and not full writes in_keycode at the tail. count updates on the next edge, so the entry is visible on DATA one cycle after the push.
- Push when full: the keycode is dropped and overflow is set. The exception is a DATA pop in the same cycle: the pop frees a slot, the push is accepted, and count is unchanged.
- Push and pop in the same cycle when empty: the pop is ignored (the read returns valid=0), the push is accepted, and count becomes 1.
- Push and pop in the same cycle otherwise: both take effect and count is unchanged.
- Flush: pointers and count go to 0 on that edge. A push in the same cycle is dropped and does NOT set overflow. overflow itself is unaffected.
- Overflow clear and a new overflow event in the same cycle: set wins.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits and ranges 0..DEPTH.
- Reset asserted mid-transfer: all state returns to the reset values on that edge, and stored keycodes are discarded.

Optional Feature:
- Macro KEYCODE_IRQ_EN.
- Defined: the irq port exists and is registered: irq = irq_en & (~empty | overflow), updated one cycle after the state that drives it. It deasserts one cycle after the FIFO drains and overflow is cleared.
- Undefined: no irq port and no irq logic. CONTROL bit 0 still reads and writes but has no effect.

Decomposition:
- Package keycode_rx_pkg holds:
  - register address constants REG_DATA=0, REG_STATUS=1, REG_CTRL=2;
  - bit-index constants VALID_BIT=8, EMPTY_BIT=8, FULL_BIT=9, OVF_BIT=10, IRQEN_BIT=0, FLUSH_BIT=1.
- One sub-module, keycode_sync_fifo (DEPTH, KW). It contains the storage array, pointers, count, full/empty, and push/pop/flush inputs.
- The top level holds the Avalon decode, overflow, control and irq logic.

Test Plan:
- Reset, then read addresses 0..3 -> readdata = 0x0, 0x100 (empty), 0x0, 0x0; in_ready=1.
- Push 0x1C, 0x32 on consecutive cycles, then read DATA twice -> 0x11C then 0x132; next read returns 0x000; STATUS count goes 2 -> 1 -> 0.
- Push 9 keycodes 0x01..0x09 (DEPTH=8) -> STATUS = 0x608 (full, overflow, count 8), in_ready=0. Drain 8 reads -> 0x101..0x108; write STATUS 0x400 -> overflow cleared.
- Full FIFO, push 0x77 in the same cycle as a DATA read -> read returns the old head, count stays 8, overflow stays 0, and 0x77 is read last.
- Empty FIFO, push 0x5A in the same cycle as a DATA read -> read returns 0x000, count becomes 1, and the next read returns 0x15A.
- KEYCODE_IRQ_EN defined, irq_en=1: push 0x29 -> irq=1 one cycle after count=1. Write CONTROL 0x3 (flush) -> count=0 and irq=0 on the following cycle; a push in the flush cycle is lost and overflow stays 0.

Source files
------------

// File: rtl/keycode_rx_pkg.sv
// Shared constants for the keycode receive FIFO: Avalon register addresses
// and the bit positions used inside the DATA, STATUS and CONTROL words.
package keycode_rx_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;

  localparam int VALID_BIT = 8;
  localparam int EMPTY_BIT = 8;
  localparam int FULL_BIT  = 9;
  localparam int OVF_BIT   = 10;
  localparam int IRQEN_BIT = 0;
  localparam int FLUSH_BIT = 1;

endpackage

// File: rtl/keycode_sync_fifo.sv
// Single-clock FIFO holding keycodes until the CPU reads them.
// Push is refused when full unless a pop happens in the same cycle;
// pop is ignored when empty; flush empties the FIFO and drops any push.
module keycode_sync_fifo
  import keycode_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KW    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [KW-1:0]              i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [KW-1:0]              o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [KW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [AW:0]   r_count;

  logic w_full;
  logic w_empty;
  logic w_popOk;
  logic w_pushOk;

  assign w_full   = (r_count == (AW+1)'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_popOk  = i_pop & ~w_empty & ~i_flush;
  assign w_pushOk = i_push & ~i_flush & (~w_full | w_popOk);

  // Pointer and occupancy bookkeeping; flush and reset both return to empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_pushOk) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_popOk)  r_rdPtr <= r_rdPtr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_pushOk} - {{AW{1'b0}}, w_popOk};
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (!reset && w_pushOk) r_mem[r_wrPtr] <= i_data;
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = w_empty;

endmodule

// File: rtl/keycode_rx_fifo.sv
// Keycode receive FIFO with a 4-word zero-wait-state Avalon-MM slave.
// Fabric pushes keycodes; the CPU pops them by reading DATA.
// Optional interrupt output enabled by defining KEYCODE_IRQ_EN.
module keycode_rx_fifo
  import keycode_rx_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int KW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    address,
  input  logic          chipselect,
  input  logic          read_n,
  input  logic          write_n,
  input  logic [31:0]   writedata,
  output logic [31:0]   readdata,
  input  logic [KW-1:0] in_keycode,
  input  logic          in_valid,
  output logic          in_ready
`ifdef KEYCODE_IRQ_EN
  ,
  output logic          irq
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic          w_rdStrobe;
  logic          w_wrStrobe;
  logic          w_pop;
  logic          w_flush;
  logic          w_ovfSet;
  logic          w_ovfClr;
  logic [KW-1:0] w_head;
  logic [AW:0]   w_count;
  logic          w_full;
  logic          w_empty;
  logic          w_unused;

  logic          r_overflow;
  logic          r_irqEn;

  assign w_rdStrobe = chipselect & ~read_n;
  assign w_wrStrobe = chipselect & ~write_n;
  assign w_pop      = w_rdStrobe & (address == REG_DATA) & ~w_empty;
  assign w_flush    = w_wrStrobe & (address == REG_CTRL) & writedata[FLUSH_BIT];
  assign w_ovfSet   = in_valid & w_full & ~w_pop & ~w_flush;
  assign w_ovfClr   = w_wrStrobe & (address == REG_STATUS) & writedata[OVF_BIT];
  assign w_unused   = &{1'b0, writedata[31:11], writedata[9:2]};

  keycode_sync_fifo #(
    .DEPTH (DEPTH),
    .KW    (KW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (in_valid),
    .i_data  (in_keycode),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign in_ready = ~w_full;

  // Sticky overflow flag and interrupt-enable bit; a new overflow beats a clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
      r_irqEn    <= 1'b0;
    end else begin
      r_overflow <= w_ovfSet | (r_overflow & ~w_ovfClr);
      if (w_wrStrobe && (address == REG_CTRL)) r_irqEn <= writedata[IRQEN_BIT];
    end
  end

  // Read mux; unselected, write-only and empty DATA reads all return zero.
  always_comb begin
    readdata = '0;
    if (w_rdStrobe) begin
      case (address)
        REG_DATA: begin
          if (!w_empty) begin
            readdata[KW-1:0]      = w_head;
            readdata[VALID_BIT]   = 1'b1;
          end
        end
        REG_STATUS: begin
          readdata[AW:0]      = w_count;
          readdata[EMPTY_BIT] = w_empty;
          readdata[FULL_BIT]  = w_full;
          readdata[OVF_BIT]   = r_overflow;
        end
        REG_CTRL: begin
          readdata[IRQEN_BIT] = r_irqEn;
        end
        default: begin
          readdata = '0;
        end
      endcase
    end
  end

`ifdef KEYCODE_IRQ_EN
  logic r_irq;

  // Interrupt raised while data is pending or an overflow is latched.
  always_ff @(posedge clk) begin
    if (reset) r_irq <= 1'b0;
    else       r_irq <= r_irqEn & (~w_empty | r_overflow);
  end

  assign irq = r_irq;
`endif

endmodule

// File: tb/tb_keycode_rx_fifo.sv
// Directed testbench for keycode_rx_fifo with a keycode scoreboard queue.
// Interrupt checks are included when KEYCODE_IRQ_EN is defined.
module tb_keycode_rx_fifo;

  logic        clk;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        read_n;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_keycode;
  logic        in_valid;
  logic        in_ready;
`ifdef KEYCODE_IRQ_EN
  logic        irq;
`endif

  int checks   = 0;
  int failures = 0;
  logic [7:0] sbQ [$];

  keycode_rx_fifo #(
    .DEPTH (8),
    .KW    (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .read_n     (read_n),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_keycode (in_keycode),
    .in_valid   (in_valid),
    .in_ready   (in_ready)
`ifdef KEYCODE_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One bus/push cycle: drive, sample readdata mid-cycle, clock, return to idle.
  task automatic applyStimulus(input logic cs, input logic rd, input logic wr,
                               input logic [1:0] addr, input logic [31:0] wdata,
                               input logic valid, input logic [7:0] key,
                               output logic [31:0] rdata);
    chipselect = cs;
    read_n     = ~rd;
    write_n    = ~wr;
    address    = addr;
    writedata  = wdata;
    in_valid   = valid;
    in_keycode = key;
    #1;
    rdata = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    read_n     = 1'b1;
    write_n    = 1'b1;
    address    = 2'd0;
    writedata  = 32'd0;
    in_valid   = 1'b0;
    in_keycode = 8'd0;
  endtask

  task automatic busRead(input logic [1:0] addr, output logic [31:0] rdata);
    applyStimulus(1'b1, 1'b1, 1'b0, addr, 32'd0, 1'b0, 8'd0, rdata);
  endtask

  task automatic busWrite(input logic [1:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    applyStimulus(1'b1, 1'b0, 1'b1, addr, wdata, 1'b0, 8'd0, dummy);
  endtask

  task automatic pushKey(input logic [7:0] key);
    logic [31:0] dummy;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b1, key, dummy);
  endtask

  task automatic idleCycle();
    logic [31:0] dummy;
    applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0, 8'd0, dummy);
  endtask

  // Expected DATA word: head of the scoreboard with valid bit, or zero when empty.
  function automatic logic [31:0] expectHead();
    logic [31:0] v;
    v = 32'd0;
    if (sbQ.size() != 0) v = {23'd0, 1'b1, sbQ.pop_front()};
    return v;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [31:0] exp;

    reset = 1'b1; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
    address = 2'd0; writedata = 32'd0; in_valid = 1'b0; in_keycode = 8'd0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    busRead(2'd0, rd); checkOutput("rst_data", rd, 32'h000);
    busRead(2'd1, rd); checkOutput("rst_status", rd, 32'h100);
    busRead(2'd2, rd); checkOutput("rst_ctrl", rd, 32'h000);
    busRead(2'd3, rd); checkOutput("rst_addr3", rd, 32'h000);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd1);
`ifdef KEYCODE_IRQ_EN
    checkOutput("rst_irq", {31'd0, irq}, 32'd0);
`endif

    // Two pushes, drain in order
    pushKey(8'h1C); sbQ.push_back(8'h1C);
    pushKey(8'h32); sbQ.push_back(8'h32);
    busRead(2'd1, rd); checkOutput("two_count2", rd, 32'h002);
    exp = expectHead(); busRead(2'd0, rd); checkOutput("two_data0", rd, exp);
    busRead(2'd1, rd); checkOutput("two_count1", rd, 32'h001);
    exp = expectHead(); busRead(2'd0, rd); checkOutput("two_data1", rd, exp);
    busRead(2'd1, rd); checkOutput("two_count0", rd, 32'h100);
    busRead(2'd0, rd); checkOutput("two_empty", rd, 32'h000);

    // Overflow: nine pushes into eight slots
    for (int i = 1; i <= 9; i++) begin
      pushKey(8'(i));
      if (i <= 8) sbQ.push_back(8'(i));
    end
    busRead(2'd1, rd); checkOutput("ovf_status", rd, 32'h608);
    checkOutput("ovf_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      exp = expectHead(); busRead(2'd0, rd);
      checkOutput($sformatf("ovf_drain%0d", i), rd, exp);
    end
    busRead(2'd1, rd); checkOutput("ovf_sticky", rd, 32'h500);
    busWrite(2'd1, 32'h400);
    busRead(2'd1, rd); checkOutput("ovf_cleared", rd, 32'h100);

    // Full FIFO with simultaneous push and pop
    for (int i = 0; i < 8; i++) begin
      pushKey(8'h10 + 8'(i)); sbQ.push_back(8'h10 + 8'(i));
    end
    exp = expectHead();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 8'h77, rd);
    sbQ.push_back(8'h77);
    checkOutput("full_pp_data", rd, exp);
    busRead(2'd1, rd); checkOutput("full_pp_status", rd, 32'h208);
    for (int i = 0; i < 8; i++) begin
      exp = expectHead(); busRead(2'd0, rd);
      checkOutput($sformatf("full_pp_drain%0d", i), rd, exp);
    end
    checkOutput("full_pp_last", rd, 32'h177);

    // Empty FIFO with simultaneous push and pop
    exp = expectHead();
    applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 1'b1, 8'h5A, rd);
    sbQ.push_back(8'h5A);
    checkOutput("empty_pp_data", rd, exp);
    busRead(2'd1, rd); checkOutput("empty_pp_status", rd, 32'h001);
    exp = expectHead(); busRead(2'd0, rd); checkOutput("empty_pp_next", rd, exp);

    // Interrupt enable and flush with a colliding push
    busWrite(2'd2, 32'h1);
    busRead(2'd2, rd); checkOutput("ctrl_irqen", rd, 32'h001);
    pushKey(8'h29); sbQ.push_back(8'h29);
`ifdef KEYCODE_IRQ_EN
    checkOutput("irq_lag", {31'd0, irq}, 32'd0);
    idleCycle();
    checkOutput("irq_set", {31'd0, irq}, 32'd1);
`endif
    applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 32'h3, 1'b1, 8'h44, rd);
    sbQ.delete();
`ifdef KEYCODE_IRQ_EN
    idleCycle();
    checkOutput("irq_clear", {31'd0, irq}, 32'd0);
`endif
    busRead(2'd1, rd); checkOutput("flush_status", rd, 32'h100);
    busRead(2'd2, rd); checkOutput("flush_selfclr", rd, 32'h001);
    busRead(2'd0, rd); checkOutput("flush_data", rd, 32'h000);

    // Reset in the middle of activity
    pushKey(8'hA1); pushKey(8'hA2); pushKey(8'hA3);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    busRead(2'd1, rd); checkOutput("mid_rst_status", rd, 32'h100);
    busRead(2'd2, rd); checkOutput("mid_rst_ctrl", rd, 32'h000);
    busRead(2'd0, rd); checkOutput("mid_rst_data", rd, 32'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
